// File: rtl/cigar_max_capture_pkg.sv
// rtl/cigar_max_capture_pkg.sv - shared widths, flush latency and FSM encoding for max capture
package cigar_max_capture_pkg;

  localparam int CMP_WIDTH_DEF      = 16;
  localparam int LOCATION_WIDTH_DEF = 32;
  localparam int TAG_WIDTH_DEF      = 8;
  // Comparator input delay (6) plus compare stages; retune here when the comparator changes.
  localparam int FLUSH_LAT_DEF      = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;
  localparam logic [1:0] ST_CAPTURE = 2'd3;

endpackage

// File: rtl/cigar_max_capture_result_fifo2.sv
// rtl/cigar_max_capture_result_fifo2.sv - 2-entry result FIFO with registered head and full flag
module cigar_result_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             full
);

  logic [1:0]       count;
  logic [WIDTH-1:0] tail;
  logic             pop;

  assign pop       = out_valid && out_ready;
  assign out_valid = (count != 2'd0);
  assign full      = (count == 2'd2);

  // out_data is the head register itself, so it holds its last value while empty.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      count    <= 2'd0;
      out_data <= '0;
      tail     <= '0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            out_data <= in_data;
            count    <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            out_data <= in_data;
          end else if (push) begin
            tail  <= in_data;
            count <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            out_data <= tail;
            if (push) tail <= in_data;
            else      count <= 2'd1;
          end
        end
        default: count <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/cigar_max_capture.sv
// rtl/cigar_max_capture.sv - sequences the max comparator per alignment and queues final max/location results
module cigar_max_capture
  import cigar_max_capture_pkg::*;
#(
  parameter int CMP_WIDTH      = CMP_WIDTH_DEF,
  parameter int LOCATION_WIDTH = LOCATION_WIDTH_DEF,
  parameter int FLUSH_LAT      = FLUSH_LAT_DEF,
  parameter int TAG_WIDTH      = TAG_WIDTH_DEF
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic                        start_in,
  input  logic                        mode_in,
  input  logic                        done_in,
  input  logic [CMP_WIDTH-1:0]        max_in,
  input  logic [LOCATION_WIDTH-1:0]   location_in,
  output logic                        cmp_en,
  output logic                        cmp_clear,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [CMP_WIDTH-1:0]        res_score,
  output logic [LOCATION_WIDTH/2-1:0] res_row,
  output logic [LOCATION_WIDTH/2-1:0] res_col,
  output logic                        res_mode,
  output logic [TAG_WIDTH-1:0]        res_tag,
  output logic                        busy,
  output logic                        err_overlap
);

  localparam int CNT_W = (FLUSH_LAT > 1) ? $clog2(FLUSH_LAT) : 1;
  localparam int DW    = CMP_WIDTH + LOCATION_WIDTH + 1 + TAG_WIDTH;

  logic [1:0]           state;
  logic                 mode_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [CNT_W-1:0]     flush_cnt;
  logic                 clear_q;
  logic                 err_q;
  logic                 fifo_full;
  logic                 fifo_pop;
  logic                 push;
  logic [DW-1:0]        head;

  assign fifo_pop = res_valid && res_ready;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept the capture.
  assign push     = (state == ST_CAPTURE) && (!fifo_full || fifo_pop);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ST_IDLE;
      mode_q    <= 1'b0;
      tag_q     <= '0;
      flush_cnt <= '0;
      clear_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      clear_q <= 1'b0;
      if (start_in && (state != ST_IDLE)) err_q <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (start_in) begin
            state   <= ST_RUN;
            mode_q  <= mode_in;
            clear_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (done_in) begin
            state     <= ST_DRAIN;
            flush_cnt <= CNT_W'(FLUSH_LAT - 1);
          end
        end
        ST_DRAIN: begin
          if (flush_cnt == '0) state <= ST_CAPTURE;
          else                 flush_cnt <= flush_cnt - 1'b1;
        end
        ST_CAPTURE: begin
          if (push) begin
            state <= ST_IDLE;
            tag_q <= tag_q + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  cigar_result_fifo2 #(.WIDTH(DW)) u_fifo (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .push      (push),
    .in_data   ({max_in, location_in, mode_q, tag_q}),
    .out_ready (res_ready),
    .out_valid (res_valid),
    .out_data  (head),
    .full      (fifo_full)
  );

  assign res_tag     = head[TAG_WIDTH-1:0];
  assign res_mode    = head[TAG_WIDTH];
  assign res_col     = head[TAG_WIDTH+1 +: LOCATION_WIDTH/2];
  assign res_row     = head[TAG_WIDTH+1+LOCATION_WIDTH/2 +: LOCATION_WIDTH/2];
  assign res_score   = head[TAG_WIDTH+1+LOCATION_WIDTH +: CMP_WIDTH];
  assign cmp_en      = (state == ST_RUN) || (state == ST_DRAIN);
  assign cmp_clear   = clear_q;
  assign busy        = (state != ST_IDLE);
  assign err_overlap = err_q;

endmodule

// File: tb/tb_cigar_max_capture.sv
// tb/tb_cigar_max_capture.sv - directed vector bench for cigar_max_capture
module tb_cigar_max_capture;
  import cigar_max_capture_pkg::*;

  localparam int FL = FLUSH_LAT_DEF;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        start_in, mode_in, done_in, res_ready;
  logic [15:0] max_in;
  logic [31:0] location_in;
  logic        cmp_en, cmp_clear, res_valid, res_mode, busy, err_overlap;
  logic [15:0] res_score, res_row, res_col;
  logic [7:0]  res_tag;

  int passed = 0;
  int total  = 0;
  int exp_tag = 0;

  typedef struct {
    logic        mode;
    logic [15:0] score;
    logic [31:0] loc;
    logic [15:0] e_score;
    logic [15:0] e_row;
    logic [15:0] e_col;
    logic        e_mode;
  } vec_t;

  vec_t vecs[4];

  cigar_max_capture dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .start_in    (start_in),
    .mode_in     (mode_in),
    .done_in     (done_in),
    .max_in      (max_in),
    .location_in (location_in),
    .cmp_en      (cmp_en),
    .cmp_clear   (cmp_clear),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_score   (res_score),
    .res_row     (res_row),
    .res_col     (res_col),
    .res_mode    (res_mode),
    .res_tag     (res_tag),
    .busy        (busy),
    .err_overlap (err_overlap)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // start pulse, clear-pulse checks, then done_in sampled 'delay' edges after start
  task automatic start_align(input logic m, input int delay);
    mode_in  = m;
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    check("clear_on", 64'(cmp_clear), 64'd1);
    check("en_on", 64'(cmp_en), 64'd1);
    step();
    check("clear_off", 64'(cmp_clear), 64'd0);
    repeat (delay - 2) step();
    done_in = 1'b1;
    step();
    done_in = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!res_valid && n < 60) begin
      step();
      n++;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 60) begin
      step();
      n++;
    end
    check("idle_timeout", 64'(busy), 64'd0);
  endtask

  initial begin
    int n;
    vecs[0] = '{1'b0, 16'd37,    32'h0012_0034, 16'h0025, 16'h0012, 16'h0034, 1'b0};
    vecs[1] = '{1'b1, 16'hFFFB,  32'hABCD_0001, 16'hFFFB, 16'hABCD, 16'h0001, 1'b1};
    vecs[2] = '{1'b0, 16'h7FFF,  32'hFFFF_FFFF, 16'h7FFF, 16'hFFFF, 16'hFFFF, 1'b0};
    vecs[3] = '{1'b1, 16'h8000,  32'h0000_0000, 16'h8000, 16'h0000, 16'h0000, 1'b1};

    sys_rst_n = 1'b0;
    start_in = 1'b0; mode_in = 1'b0; done_in = 1'b0; res_ready = 1'b1;
    max_in = '0; location_in = '0;
    step(); step();
    check("rst_valid", 64'(res_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_en", 64'(cmp_en), 64'd0);
    check("rst_err", 64'(err_overlap), 64'd0);
    check("rst_score", 64'(res_score), 64'd0);
    sys_rst_n = 1'b1;
    step();

    // done_in while idle is ignored
    done_in = 1'b1;
    step();
    done_in = 1'b0;
    step();
    check("idle_done_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 4; i++) begin
      max_in = vecs[i].score;
      location_in = vecs[i].loc;
      start_align(vecs[i].mode, 5);
      wait_valid(n);
      check("latency", 64'(n), 64'(FL + 1));
      check("score", 64'(res_score), 64'(vecs[i].e_score));
      check("row", 64'(res_row), 64'(vecs[i].e_row));
      check("col", 64'(res_col), 64'(vecs[i].e_col));
      check("mode", 64'(res_mode), 64'(vecs[i].e_mode));
      check("tag", 64'(res_tag), 64'(exp_tag));
      check("busy_after", 64'(busy), 64'd0);
      exp_tag++;
      step();
      check("popped", 64'(res_valid), 64'd0);
    end

    // back-pressure: two queue, third stalls in CAPTURE
    res_ready = 1'b0;
    max_in = 16'd100; location_in = 32'h0001_0002;
    start_align(1'b0, 3);
    wait_idle();
    max_in = 16'd200;
    start_align(1'b0, 3);
    wait_idle();
    check("bp_valid", 64'(res_valid), 64'd1);
    check("bp_head_tag", 64'(res_tag), 64'(exp_tag));
    max_in = 16'd300;
    start_align(1'b1, 3);
    repeat (FL + 4) step();
    check("bp_busy", 64'(busy), 64'd1);
    check("bp_en", 64'(cmp_en), 64'd0);
    check("bp_hold", 64'(res_score), 64'd100);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("bp_cap_idle", 64'(busy), 64'd0);
    check("bp_second", 64'(res_score), 64'd200);
    check("bp_second_tag", 64'(res_tag), 64'(exp_tag + 1));
    res_ready = 1'b1;
    step();
    check("bp_third", 64'(res_score), 64'd300);
    check("bp_third_tag", 64'(res_tag), 64'(exp_tag + 2));
    check("bp_third_mode", 64'(res_mode), 64'd1);
    step();
    check("bp_empty", 64'(res_valid), 64'd0);
    exp_tag += 3;

    // overlap during DRAIN
    max_in = 16'd55; location_in = 32'h0003_0004;
    start_align(1'b0, 3);
    step(); step();
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    check("ovl_err", 64'(err_overlap), 64'd1);
    check("ovl_busy", 64'(busy), 64'd1);
    check("ovl_noclear", 64'(cmp_clear), 64'd0);
    wait_valid(n);
    check("ovl_score", 64'(res_score), 64'd55);
    check("ovl_tag", 64'(res_tag), 64'(exp_tag));
    exp_tag++;
    step();
    check("ovl_sticky", 64'(err_overlap), 64'd1);

    // reset mid-DRAIN with one result queued
    res_ready = 1'b0;
    max_in = 16'd77;
    start_align(1'b1, 3);
    wait_idle();
    check("rq_valid", 64'(res_valid), 64'd1);
    start_align(1'b0, 3);
    step();
    #2 sys_rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(res_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_en", 64'(cmp_en), 64'd0);
    check("arst_err", 64'(err_overlap), 64'd0);
    check("arst_score", 64'(res_score), 64'd0);
    check("arst_tag", 64'(res_tag), 64'd0);
    step();
    sys_rst_n = 1'b1;
    res_ready = 1'b1;
    exp_tag = 0;
    step();
    max_in = 16'd9;
    start_align(1'b0, 4);
    wait_valid(n);
    check("post_rst_tag", 64'(res_tag), 64'd0);
    check("post_rst_score", 64'(res_score), 64'd9);
    step();

    // tag wrap: 256 more alignments after the one above
    for (int i = 1; i <= 256; i++) begin
      max_in = 16'(i);
      start_align(1'b0, 2);
      wait_valid(n);
      check("wrap_tag", 64'(res_tag), 64'(i % 256));
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
